// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through UART receive FIFO with sticky flags; define UART_RX_FIFO_ERR_EN to store parity/stop bits per entry
module uart_rx_fifo #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int COUNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [MAX_UART_DATA_W-1:0] data_i,
  input  logic                       parity_err_i,
  input  logic                       stop_err_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic                       clr_err_i,
  input  logic [COUNT_W-1:0]         thresh_i,
  output logic [MAX_UART_DATA_W-1:0] data_o,
  output logic                       parity_err_o,
  output logic                       stop_err_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [COUNT_W-1:0]         count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       level_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef UART_RX_FIFO_ERR_EN
  localparam int ENT_W = MAX_UART_DATA_W + 2;
`else
  localparam int ENT_W = MAX_UART_DATA_W;
`endif
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W-1:0]   r_wr;
  logic [COUNT_W-1:0] r_count;
  logic               r_empty;
  logic               r_full;
  logic               r_level;
  logic               r_ovf;
  logic               r_udf;
  logic               w_push;
  logic               w_pop;
  logic [COUNT_W-1:0] w_count_n;
  logic [ENT_W-1:0]   w_wdata;
  logic [ENT_W-1:0]   w_head;
  assign w_pop     = pop_i & ~r_empty & ~flush_i;
  assign w_push    = push_i & (~r_full | w_pop) & ~flush_i;
  assign w_count_n = flush_i ? '0 : r_count + COUNT_W'(w_push) - COUNT_W'(w_pop);
  assign w_head    = r_mem[r_rd];
  assign data_o    = w_head[MAX_UART_DATA_W-1:0];
`ifdef UART_RX_FIFO_ERR_EN
  assign w_wdata      = {stop_err_i, parity_err_i, data_i};
  assign parity_err_o = w_head[MAX_UART_DATA_W];
  assign stop_err_o   = w_head[MAX_UART_DATA_W+1];
`else
  logic w_unused;
  assign w_wdata      = data_i;
  assign parity_err_o = 1'b0;
  assign stop_err_o   = 1'b0;
  assign w_unused     = parity_err_i ^ stop_err_i;
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) r_mem[r_wr] <= w_wdata;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_level <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_rd    <= flush_i ? '0 : r_rd + PTR_W'(w_pop);
      r_wr    <= flush_i ? '0 : r_wr + PTR_W'(w_push);
      r_count <= w_count_n;
      r_empty <= w_count_n == '0;
      r_full  <= w_count_n == COUNT_W'(FIFO_DEPTH);
      r_level <= (thresh_i != '0) && (w_count_n >= thresh_i);
      r_ovf   <= (~flush_i & push_i & r_full & ~pop_i) | (r_ovf & ~clr_err_i);
      r_udf   <= (~flush_i & pop_i & r_empty) | (r_udf & ~clr_err_i);
    end
  end
  assign count_o     = r_count;
  assign empty_o     = r_empty;
  assign full_o      = r_full;
  assign level_o     = r_level;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_udf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-based self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       push_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       parity_err_i = 1'b0;
  logic       stop_err_i = 1'b0;
  logic       pop_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [4:0] thresh_i = '0;
  logic [7:0] data_o;
  logic       parity_err_o;
  logic       stop_err_o;
  logic       empty_o;
  logic       full_o;
  logic [4:0] count_o;
  logic       overflow_o;
  logic       underflow_o;
  logic       level_o;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp;
  uart_rx_fifo dut (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(push_i), .data_i(data_i),
    .parity_err_i(parity_err_i), .stop_err_i(stop_err_i), .pop_i(pop_i),
    .flush_i(flush_i), .clr_err_i(clr_err_i), .thresh_i(thresh_i),
    .data_o(data_o), .parity_err_o(parity_err_o), .stop_err_o(stop_err_o),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .level_o(level_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic drive(input logic ps, input logic [7:0] d, input logic pp, input logic fl,
                       input logic ce, input logic pe, input logic se);
    push_i = ps;
    data_i = d;
    pop_i = pp;
    flush_i = fl;
    clr_err_i = ce;
    parity_err_i = pe;
    stop_err_i = se;
    @(posedge clk_i);
    #1;
    push_i = 1'b0;
    pop_i = 1'b0;
    flush_i = 1'b0;
    clr_err_i = 1'b0;
    parity_err_i = 1'b0;
    stop_err_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    drive(1, 8'hFF, 1, 0, 0, 1, 1);
    rst_i = 1'b0;
    q.delete();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b expected 0", underflow_o); end
    checks++; if (level_o !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", level_o); end
  endtask
  task automatic test_basic;
    q.push_back(8'hA5);
    drive(1, 8'hA5, 0, 0, 0, 0, 0);
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", empty_o); end
    checks++; if (data_o !== q[0]) begin errors++; $display("FAIL basic_head: got %h expected %h", data_o, q[0]); end
    q.push_back(8'h3C);
    drive(1, 8'h3C, 0, 0, 0, 0, 0);
    while (q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (data_o !== exp) begin errors++; $display("FAIL basic_pop: got %h expected %h", data_o, exp); end
      drive(0, 8'h00, 1, 0, 0, 0, 0);
      checks++; if (int'(count_o) !== q.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", count_o, q.size()); end
      if (q.size() > 0) begin
        checks++; if (data_o !== q[0]) begin errors++; $display("FAIL basic_next: got %h expected %h", data_o, q[0]); end
      end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL basic_drained: got %b expected 1", empty_o); end
  endtask
  task automatic test_overflow;
    for (int i = 0; i < 17; i++) begin
      if (q.size() < 16) q.push_back(8'(i));
      drive(1, 8'(i), 0, 0, 0, 0, 0);
      if (i == 15) begin
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow_o); end
      end
    end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_o); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count_o); end
    while (q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (data_o !== exp) begin errors++; $display("FAIL ovf_order: got %h expected %h", data_o, exp); end
      drive(0, 8'h00, 1, 0, 0, 0, 0);
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty_o); end
    drive(0, 8'h00, 0, 0, 1, 0, 0);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow_o); end
  endtask
  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'h40 + 8'(i));
      drive(1, 8'h40 + 8'(i), 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
      exp = q.pop_front();
      checks++; if (data_o !== exp) begin errors++; $display("FAIL fpp_order: got %h expected %h", data_o, exp); end
      q.push_back(8'h80 + 8'(i));
      drive(1, 8'h80 + 8'(i), 1, 0, 0, 0, 0);
      checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d expected 16", count_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow_o); end
    end
    while (q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (data_o !== exp) begin errors++; $display("FAIL fpp_drain: got %h expected %h", data_o, exp); end
      drive(0, 8'h00, 1, 0, 0, 0, 0);
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %b expected 1", empty_o); end
  endtask
  task automatic test_underflow;
    q.push_back(8'h55);
    drive(1, 8'h55, 1, 0, 0, 0, 0);
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", underflow_o); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL udf_count: got %0d expected 1", count_o); end
    checks++; if (data_o !== q[0]) begin errors++; $display("FAIL udf_data: got %h expected %h", data_o, q[0]); end
    drive(0, 8'h00, 0, 0, 1, 0, 0);
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL udf_clr: got %b expected 0", underflow_o); end
    exp = q.pop_front();
    checks++; if (data_o !== exp) begin errors++; $display("FAIL udf_pop: got %h expected %h", data_o, exp); end
    drive(0, 8'h00, 1, 0, 0, 0, 0);
    drive(0, 8'h00, 1, 0, 1, 0, 0);
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL udf_clr_race: got %b expected 1", underflow_o); end
    drive(0, 8'h00, 0, 0, 1, 0, 0);
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL udf_clr2: got %b expected 0", underflow_o); end
  endtask
  task automatic test_level_flush;
    thresh_i = 5'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h10 + 8'(i), 0, 0, 0, 0, 0);
      checks++; if (level_o !== (i == 3)) begin errors++; $display("FAIL lvl_step%0d: got %b expected %b", i, level_o, i == 3); end
      checks++; if (int'(count_o) !== i + 1) begin errors++; $display("FAIL lvl_count%0d: got %0d expected %0d", i, count_o, i + 1); end
    end
    drive(1, 8'h99, 0, 1, 0, 0, 0);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty_o); end
    checks++; if (level_o !== 1'b0) begin errors++; $display("FAIL flush_level: got %b expected 0", level_o); end
    drive(0, 8'h00, 1, 0, 0, 0, 0);
    drive(0, 8'h00, 0, 1, 0, 0, 0);
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL flush_sticky: got %b expected 1", underflow_o); end
    drive(0, 8'h00, 0, 0, 1, 0, 0);
    thresh_i = 5'd0;
    drive(1, 8'h21, 0, 0, 0, 0, 0);
    checks++; if (level_o !== 1'b0) begin errors++; $display("FAIL lvl_zero: got %b expected 0", level_o); end
    thresh_i = 5'd1;
    drive(1, 8'h22, 0, 0, 0, 0, 0);
    checks++; if (level_o !== 1'b1) begin errors++; $display("FAIL lvl_one: got %b expected 1", level_o); end
    drive(0, 8'h00, 0, 1, 0, 0, 0);
    thresh_i = 5'd0;
  endtask
  task automatic test_err_bits_reset;
    drive(1, 8'h7E, 0, 0, 0, 0, 1);
    drive(1, 8'h11, 0, 0, 0, 1, 0);
    checks++; if (data_o !== 8'h7E) begin errors++; $display("FAIL err_data: got %h expected 7e", data_o); end
`ifdef UART_RX_FIFO_ERR_EN
    checks++; if (stop_err_o !== 1'b1) begin errors++; $display("FAIL err_stop: got %b expected 1", stop_err_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL err_par0: got %b expected 0", parity_err_o); end
    drive(0, 8'h00, 1, 0, 0, 0, 0);
    checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL err_par1: got %b expected 1", parity_err_o); end
    checks++; if (stop_err_o !== 1'b0) begin errors++; $display("FAIL err_stop0: got %b expected 0", stop_err_o); end
`else
    checks++; if (stop_err_o !== 1'b0) begin errors++; $display("FAIL err_stop_tied: got %b expected 0", stop_err_o); end
    drive(0, 8'h00, 1, 0, 0, 0, 0);
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL err_par_tied: got %b expected 0", parity_err_o); end
`endif
    checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL err_next: got %h expected 11", data_o); end
    rst_i = 1'b1;
    drive(1, 8'h33, 1, 0, 0, 0, 0);
    rst_i = 1'b0;
    q.delete();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %b expected 1", empty_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", count_o); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_level_flush();
    test_err_bits_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_W, default 8: received data width, matching the controller rx_data_o width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: number of entries, power of two and >= 2.
REQ-003 SHALL have parameter COUNT_W, default $clog2(FIFO_DEPTH)+1: occupancy width.
REQ-004 SHALL have port clk_i, input, 1: single clock shared with the controller.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port push_i, input, 1: write strobe, driven from controller rx_fifo_push_o.
REQ-007 SHALL have port data_i, input, MAX_UART_DATA_W: write data, driven from rx_data_o.
REQ-008 SHALL have port parity_err_i, input, 1: parity error of the frame being written.
REQ-009 SHALL have port stop_err_i, input, 1: stop error of the frame being written.
REQ-010 SHALL have port pop_i, input, 1: host read strobe.
REQ-011 SHALL have port flush_i, input, 1: discards all contents.
REQ-012 SHALL have port clr_err_i, input, 1: clears sticky flags.
REQ-013 SHALL have port thresh_i, input, COUNT_W: level threshold.
REQ-014 SHALL have port data_o, output, MAX_UART_DATA_W: head entry data.
REQ-015 SHALL have ports parity_err_o and stop_err_o, output, 1 each: head entry error bits.
REQ-016 SHALL have ports empty_o and full_o, output, 1 each: status.
REQ-017 SHALL have port count_o, output, COUNT_W: occupancy, range 0..FIFO_DEPTH.
REQ-018 SHALL have ports overflow_o and underflow_o, output, 1 each: sticky error flags.
REQ-019 SHALL have port level_o, output, 1: set when count_o >= thresh_i and thresh_i != 0.

Function
REQ-020 SHALL be first-word-fall-through: when empty_o=0, data_o, parity_err_o and stop_err_o present the oldest entry with no read latency.
REQ-021 SHALL make a pushed entry visible one cycle after push_i; empty_o falls and count_o increments on that same edge.
REQ-022 SHALL take pop_i with empty_o=0 as a read: the head advances on the next edge and count_o decrements.
REQ-023 SHALL use read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH with no gap.
REQ-024 SHALL, on push with full_o=1 and no pop, drop the data, leave the contents unchanged and set overflow_o on the next edge.
REQ-025 SHALL, on push and pop together with full_o=1, perform both operations; count_o stays FIFO_DEPTH and overflow_o is not set.
REQ-026 SHALL, on pop with empty_o=1, ignore the pop and set underflow_o; a push in the same cycle still completes, giving count_o=1.
REQ-027 SHALL, on push and pop together with 0<count<FIFO_DEPTH, perform both with count_o unchanged.
REQ-028 SHALL give flush_i priority over push_i and pop_i: pointers and count go to 0 on the next edge, same-cycle push and pop are discarded, and sticky flags are unaffected.
REQ-029 SHALL clear overflow_o and underflow_o on clr_err_i; a new error event in the same cycle wins, leaving the flag set.
REQ-030 SHALL drive level_o as a registered output updated from the next-state count, so it is coincident with count_o.
REQ-031 SHALL drive full_o = (count_o == FIFO_DEPTH) and empty_o = (count_o == 0), both registered.

Reset
REQ-032 SHALL, with rst_i=1 at a clk_i edge, zero pointers and count_o, giving empty_o=1, full_o=0, overflow_o=0, underflow_o=0 and level_o=0.
REQ-033 SHALL not reset storage; data_o, parity_err_o and stop_err_o are don't-care while empty_o=1.
REQ-034 SHALL give rst_i priority over every other input, including a mid-stream push or pop.

Configuration
REQ-035 SHALL define macro UART_RX_FIFO_ERR_EN so that, when defined, each entry stores parity and stop error bits with the data (width MAX_UART_DATA_W+2).
REQ-036 SHALL, when UART_RX_FIFO_ERR_EN is undefined, keep entries at MAX_UART_DATA_W bits, ignore parity_err_i and stop_err_i, and tie parity_err_o and stop_err_o to 0; the port list is identical in both builds.

Verification
REQ-037 SHALL be verified by: after reset, push 0xA5 then 0x3C -> cycle after the first push empty_o=0, data_o=0xA5; after one pop, data_o=0x3C and count_o=1.
REQ-038 SHALL be verified by: 17 pushes of 0x00..0x10 into DEPTH=16 -> full_o=1 after the 16th, overflow_o=1 after the 17th, pops return 0x00..0x0F and then empty_o=1.
REQ-039 SHALL be verified by: push and pop together while full -> count_o stays 16, overflow_o=0, and FIFO order is preserved across pointer wrap.
REQ-040 SHALL be verified by: pop on empty with a simultaneous push of 0x55 -> underflow_o=1, count_o=1, data_o=0x55; then clr_err_i -> underflow_o=0.
REQ-041 SHALL be verified by: thresh_i=4 with 4 pushes -> level_o=1 coincident with count_o=4; then flush_i together with a push -> count_o=0, empty_o=1, level_o=0.
REQ-042 SHALL be verified by: with UART_RX_FIFO_ERR_EN defined, push 0x7E with stop_err_i=1 -> stop_err_o=1 at head; reset asserted mid-stream -> empty_o=1 on the next edge.
